// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
// The control state encoding and counter sizing are used by the top-level multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The iteration counter spans 0..width-1, so a width of at least 2 needs $clog2(width) bits.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_mult_if.sv
// Handshake and operand/product bundle between the multiplier and its controller.
// The master side issues start and the operands; the slave side returns busy, done and the product.
interface seq_mult_if #(
    parameter int WIDTH = 4
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] p;

    modport master (
        output start, a, b,
        input  busy, done, p
    );

    modport slave (
        input  start, a, b,
        output busy, done, p
    );
endinterface

// File: rtl/seq_mult_rca_n.sv
// One-bit full-adder cell and an N-bit ripple-carry adder built from a chain of these cells.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module rca_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    logic [N:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            full_adder u_fa (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (carry[gi]),
                .s    (s[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate
endmodule

// File: rtl/seq_mult.sv
// Sequential unsigned shift-and-add multiplier: WIDTH iterations through one shared adder slice.
// The handshake is start/busy/done. The product stays on p until the next completed multiply.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_mult_if.slave bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   mcand_reg, mcand_next;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [2*WIDTH-1:0] p_reg, p_next;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               sum_carry;
    logic [2*WIDTH-1:0] acc_shift;
    logic               last_iter;

    // The multiplier LSB gates the multiplicand, so a single adder covers both "add" and "no add".
    assign addend = acc_reg[0] ? mcand_reg : '0;

    rca_n #(
        .N (WIDTH)
    ) u_rca (
        .a    (acc_reg[2*WIDTH-1:WIDTH]),
        .b    (addend),
        .cin  (1'b0),
        .s    (sum),
        .cout (sum_carry)
    );

    // The carry-out lands at the top, and the consumed multiplier bit drops off the bottom.
    assign acc_shift = {sum_carry, sum, acc_reg[WIDTH-1:1]};
    assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

    always_comb begin
        state_next = state_reg;
        mcand_next = mcand_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        p_next     = p_reg;

        case (state_reg)
            IDLE, DONE: begin
                state_next = IDLE;
                if (bus.start) begin
                    mcand_next = bus.a;
                    acc_next   = {{WIDTH{1'b0}}, bus.b};
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                acc_next = acc_shift;
                cnt_next = cnt_reg + CNT_W'(1);
                if (last_iter) begin
                    p_next     = acc_shift;
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            mcand_reg <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            p_reg     <= '0;
        end else begin
            state_reg <= state_next;
            mcand_reg <= mcand_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            p_reg     <= p_next;
        end
    end

    assign bus.busy = (state_reg == RUN);
    assign bus.done = (state_reg == DONE);
    assign bus.p    = p_reg;

endmodule

// File: tb/tb_seq_mult.sv
// Directed and random checks of seq_mult at WIDTH=4 and WIDTH=8.
// The expected products, latency and handshake timing come from the plain arithmetic model below.
module tb_seq_mult;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    seq_mult_if #(.WIDTH(4)) bus4 ();
    seq_mult_if #(.WIDTH(8)) bus8 ();

    seq_mult #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    seq_mult #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: an unsigned product, with done arriving WIDTH+1 cycles after the accepting edge.
    function automatic logic [63:0] ref_prod(input int unsigned x, input int unsigned y);
        logic [63:0] r;
        r = 64'(x) * 64'(y);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic run4(input int unsigned x, input int unsigned y, input string tag);
        int lat;
        int busy_cnt;
        logic [63:0] exp_p;
        exp_p = ref_prod(x, y);
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.a     = 4'(x);
        bus4.b     = 4'(y);
        @(negedge clk);
        bus4.start = 1'b0;
        bus4.a     = 4'($urandom);
        bus4.b     = 4'($urandom);
        lat      = 1;
        busy_cnt = 0;
        while (!bus4.done && lat < 20) begin
            if (bus4.busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd5);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd4);
        chk({tag, "_busy_done_at_done"}, 64'({bus4.busy, bus4.done}), 64'b01);
        chk({tag, "_p"}, 64'(bus4.p), exp_p);
        @(negedge clk);
        chk({tag, "_done_single"}, 64'(bus4.done), 64'd0);
        chk({tag, "_p_held"}, 64'(bus4.p), exp_p);
    endtask

    task automatic run8(input int unsigned x, input int unsigned y, input string tag, input bit full);
        int lat;
        int busy_cnt;
        logic [63:0] exp_p;
        exp_p = ref_prod(x, y);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 8'(x);
        bus8.b     = 8'(y);
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        lat      = 1;
        busy_cnt = 0;
        while (!bus8.done && lat < 30) begin
            if (bus8.busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd9);
        chk({tag, "_p"}, 64'(bus8.p), exp_p);
        if (full) begin
            chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd8);
            chk({tag, "_busy_done_at_done"}, 64'({bus8.busy, bus8.done}), 64'b01);
            @(negedge clk);
            chk({tag, "_done_single"}, 64'(bus8.done), 64'd0);
        end
    endtask

    initial begin
        int done_cnt;
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        bus4.start = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;

        repeat (3) @(negedge clk);
        chk("reset_busy4", 64'(bus4.busy), 64'd0);
        chk("reset_done4", 64'(bus4.done), 64'd0);
        chk("reset_p4", 64'(bus4.p), 64'd0);
        chk("reset_busy_done8", 64'({bus8.busy, bus8.done}), 64'd0);
        chk("reset_p8", 64'(bus8.p), 64'd0);
        rst_n = 1'b1;

        // Basic products, including the zero-operand and maximum cases.
        run4(15, 15, "w4_15x15");
        run4(0, 9, "w4_0x9");
        run4(9, 0, "w4_9x0");
        run4(1, 13, "w4_1x13");

        // Start and operand changes while RUN is in progress must be ignored.
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.a     = 4'd6;
        bus4.b     = 4'd7;
        @(negedge clk);
        bus4.a = 4'd3;
        bus4.b = 4'd3;
        chk("ign_busy_in_run", 64'({bus4.busy, bus4.done}), 64'b10);
        repeat (3) @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        chk("ign_done", 64'({bus4.busy, bus4.done}), 64'b01);
        chk("ign_p", 64'(bus4.p), ref_prod(6, 7));
        done_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus4.done) done_cnt++;
        end
        chk("ign_single_done", 64'(done_cnt), 64'd0);

        // Back-to-back multiplies with start held high: done repeats every WIDTH+1 cycles.
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.a     = 4'd3;
        bus4.b     = 4'd4;
        @(negedge clk);
        repeat (4) @(negedge clk);
        chk("b2b_done1", 64'({bus4.busy, bus4.done}), 64'b01);
        chk("b2b_p1", 64'(bus4.p), ref_prod(3, 4));
        bus4.a = 4'd11;
        bus4.b = 4'd12;
        @(negedge clk);
        chk("b2b_no_idle", 64'({bus4.busy, bus4.done}), 64'b10);
        repeat (3) @(negedge clk);
        chk("b2b_p1_held_in_run", 64'(bus4.p), ref_prod(3, 4));
        @(negedge clk);
        chk("b2b_done2", 64'({bus4.busy, bus4.done}), 64'b01);
        chk("b2b_p2", 64'(bus4.p), ref_prod(11, 12));
        bus4.start = 1'b0;
        @(negedge clk);
        chk("b2b_idle_after", 64'({bus4.busy, bus4.done}), 64'b00);

        // An asynchronous reset in the middle of RUN aborts the multiply without a done pulse.
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.a     = 4'd5;
        bus4.b     = 4'd5;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(bus4.busy), 64'd0);
        chk("rst_done", 64'(bus4.done), 64'd0);
        chk("rst_p", 64'(bus4.p), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus4.done) done_cnt++;
        end
        chk("rst_no_done", 64'(done_cnt), 64'd0);
        run4(2, 3, "w4_after_rst");

        // Eight-bit instance: the extreme case, followed by random operand pairs.
        run8(255, 255, "w8_255x255", 1'b1);
        for (int i = 0; i < 1000; i++) begin
            run8($urandom_range(0, 255), $urandom_range(0, 255), "w8_rand", 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before the end of the test");
        $fatal(1, "watchdog timeout");
    end

endmodule
